// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its issue arbiter:
//   - ALU select encodings (4-bit codes driven on alu_sel)
//   - requester index constants (also used as the response tag value)
//   - onehot2(): converts a 1-bit requester tag into a 2-bit one-hot vector
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_sel_e;

    // Requester 0 is the integer execute path, requester 1 branch/address-gen.
    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_AGEN = 1'b1;

    function automatic logic [1:0] onehot2(input logic tag);
        logic [1:0] vec;
        vec = 2'b00;
        vec[tag] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Two-input winner selection for the ALU issue arbiter.
// Build option: ALU_ARB_ROUND_ROBIN_EN
//   defined   - on a tie the requester other than last_grant wins; last_grant
//               updates only when a request transfer happens (xfer).
//   undefined - fixed priority, requester 0 wins every tie; no pointer state,
//               so clk/rst/xfer ports are not present.
// Ports:
//   clk, rst   clock / asynchronous active-high reset (round-robin build only)
//   xfer       a request transferred this cycle (round-robin build only)
//   req_valid  per-requester request valid
//   winner     index of the selected requester
// -----------------------------------------------------------------------------
module alu_rr_pick
    import alu_pkg::*;
(
`ifdef ALU_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       xfer,
`endif
    input  logic [1:0] req_valid,
    output logic       winner
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Winner selection: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        winner = REQ_EXEC;
        case (req_valid)
            2'b01:   winner = REQ_EXEC;
            2'b10:   winner = REQ_AGEN;
            2'b11:   winner = ~last_grant_r;
            default: winner = REQ_EXEC;
        endcase
    end

    // Pointer register; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (xfer) begin
            last_grant_r <= winner;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    always_comb begin
        winner = REQ_EXEC;
        case (req_valid)
            2'b10:   winner = REQ_AGEN;
            default: winner = REQ_EXEC;
        endcase
    end
`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
// Shares one combinational ALU between the execute path (requester 0) and the
// branch/address-generation path (requester 1). A winning request is
// registered into the issue stage (S1) which drives the ALU; the ALU result is
// captured into the response stage (S2) and returned to the originating
// requester with backpressure.
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see alu_rr_pick); default build is fixed priority, requester 0 first.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (at most one ready bit high)
//   req_sel/req_a/req_b  per-requester ALU select code and operands
//   alu_sel/alu_a/alu_b  issue-stage outputs to the ALU (zero when S1 empty)
//   alu_result           combinational ALU result
//   rsp_valid/rsp_ready  one-hot response valid indexed by requester, accept
//   rsp_data             response result
//   busy                 S1 or S2 holds a valid entry
// -----------------------------------------------------------------------------
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][3:0]      req_sel,
    input  logic [1:0][XLEN-1:0] req_a,
    input  logic [1:0][XLEN-1:0] req_b,
    output logic [3:0]           alu_sel,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    input  logic [XLEN-1:0]      alu_result,
    output logic [1:0]           rsp_valid,
    output logic [XLEN-1:0]      rsp_data,
    input  logic [1:0]           rsp_ready,
    output logic                 busy
);

    logic            v1_r;
    logic            tag1_r;
    logic [3:0]      sel1_r;
    logic [XLEN-1:0] a1_r;
    logic [XLEN-1:0] b1_r;
    logic            v2_r;
    logic            tag2_r;
    logic [XLEN-1:0] data2_r;

    logic s2_accept_s;
    logic s1_advance_s;
    logic s1_accept_s;
    logic rsp_fire_s;
    logic winner_s;
    logic xfer_s;

    alu_rr_pick u_pick (
`ifdef ALU_ARB_ROUND_ROBIN_EN
        .clk       (clk),
        .rst       (rst),
        .xfer      (xfer_s),
`endif
        .req_valid (req_valid),
        .winner    (winner_s)
    );

    // Pipeline flow control and grant generation.
    always_comb begin
        s2_accept_s  = !v2_r | rsp_ready[tag2_r];
        s1_advance_s = v1_r & s2_accept_s;
        s1_accept_s  = !v1_r | s1_advance_s;
        rsp_fire_s   = v2_r & rsp_ready[tag2_r];
        req_ready    = 2'b00;
        // Ready is also held low while reset is asserted so the handshake
        // outputs are quiet immediately, not just after the next edge.
        if (s1_accept_s && !rst) begin
            req_ready[winner_s] = req_valid[winner_s];
        end else begin
            req_ready = 2'b00;
        end
        xfer_s = |(req_valid & req_ready);
    end

    // Issue stage: load the granted request, otherwise empty to zeros when it
    // drains so the ALU sees ADD 0,0 while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r   <= 1'b0;
            tag1_r <= REQ_EXEC;
            sel1_r <= ALU_ADD;
            a1_r   <= '0;
            b1_r   <= '0;
        end else if (s1_accept_s) begin
            if (xfer_s) begin
                v1_r   <= 1'b1;
                tag1_r <= winner_s;
                sel1_r <= req_sel[winner_s];
                a1_r   <= req_a[winner_s];
                b1_r   <= req_b[winner_s];
            end else begin
                v1_r   <= 1'b0;
                tag1_r <= REQ_EXEC;
                sel1_r <= ALU_ADD;
                a1_r   <= '0;
                b1_r   <= '0;
            end
        end else begin
            v1_r   <= v1_r;
            tag1_r <= tag1_r;
            sel1_r <= sel1_r;
            a1_r   <= a1_r;
            b1_r   <= b1_r;
        end
    end

    // Response stage: a reload from S1 wins over a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r    <= 1'b0;
            tag2_r  <= REQ_EXEC;
            data2_r <= '0;
        end else if (s1_advance_s) begin
            v2_r    <= 1'b1;
            tag2_r  <= tag1_r;
            data2_r <= alu_result;
        end else if (rsp_fire_s) begin
            v2_r    <= 1'b0;
            tag2_r  <= REQ_EXEC;
            data2_r <= '0;
        end else begin
            v2_r    <= v2_r;
            tag2_r  <= tag2_r;
            data2_r <= data2_r;
        end
    end

    assign alu_sel   = sel1_r;
    assign alu_a     = a1_r;
    assign alu_b     = b1_r;
    assign rsp_valid = v2_r ? onehot2(tag2_r) : 2'b00;
    assign rsp_data  = data2_r;
    assign busy      = v1_r | v2_r;

endmodule
